// File: rtl/frankie_pkg.sv
// frankie_pkg: opcodes, FSM states, datapath select codes and the control-word
// layout shared by the Frankie control FSM and its strobe decoder.
package frankie_pkg;
    localparam int OPW = 4;
    localparam int STW = 4;

    localparam logic [OPW-1:0] OP_LIM  = 4'd0;
    localparam logic [OPW-1:0] OP_LIS  = 4'd1;
    localparam logic [OPW-1:0] OP_ADD  = 4'd2;
    localparam logic [OPW-1:0] OP_SUB  = 4'd3;
    localparam logic [OPW-1:0] OP_ADDI = 4'd4;
    localparam logic [OPW-1:0] OP_SLT  = 4'd5;
    localparam logic [OPW-1:0] OP_LW   = 4'd6;
    localparam logic [OPW-1:0] OP_SW   = 4'd7;
    localparam logic [OPW-1:0] OP_PUSH = 4'd8;
    localparam logic [OPW-1:0] OP_POP  = 4'd9;
    localparam logic [OPW-1:0] OP_BC   = 4'd10;
    localparam logic [OPW-1:0] OP_J    = 4'd11;
    localparam logic [OPW-1:0] OP_JAL  = 4'd12;
    localparam logic [OPW-1:0] OP_JR   = 4'd13;
    localparam logic [OPW-1:0] OP_SWAP = 4'd14;
    localparam logic [OPW-1:0] OP_HALT = 4'd15;

    typedef enum logic [STW-1:0] {
        FETCH, DECODE, WB_IMM, EXEC, WB_ALU, ADDR, MEM_RD, WB_MEM,
        MEM_WR, SP_DEC, WB_POP, BR, JMP, SWAP, HALT
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_PASSB = 2'd2, ALU_SLT = 2'd3;
    localparam logic [1:0] SRCA_MARY = 2'd0, SRCA_PC = 2'd1, SRCA_SP = 2'd2;
    localparam logic [1:0] SRCB_SHELLEY = 2'd0, SRCB_IMM = 2'd1, SRCB_ONE = 2'd2, SRCB_NEG1 = 2'd3;
    localparam logic [1:0] WBS_ALU = 2'd0, WBS_MEM = 2'd1, WBS_IMM = 2'd2, WBS_SWAP = 2'd3;
    localparam logic [1:0] PC_ALU = 2'd0, PC_JUMP = 2'd1, PC_RA = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] wb_src;
        logic       mary_write;
        logic       shelley_write;
        logic       sp_write;
        logic       ra_write;
        logic       comp_write;
        logic       halted;
    } ctrl_t;

    function automatic state_t decode_next(input logic [OPW-1:0] op);
        case (op)
            OP_LIM, OP_LIS:                  return WB_IMM;
            OP_ADD, OP_SUB, OP_ADDI, OP_SLT: return EXEC;
            OP_LW, OP_SW:                    return ADDR;
            OP_PUSH:                         return SP_DEC;
            OP_POP:                          return MEM_RD;
            OP_BC, OP_J:                     return BR;
            OP_JAL, OP_JR:                   return JMP;
            OP_SWAP:                         return SWAP;
            default:                         return HALT;
        endcase
    endfunction
endpackage

// File: rtl/frankie_control_if.sv
// frankie_control_if: opcode/flag inputs and strobe outputs between the
// Frankie control FSM (master) and the datapath (slave).
interface frankie_control_if;
    import frankie_pkg::*;
    logic [OPW-1:0] opcode;
    logic           comp;
    logic           mem_wait;
    logic           step;
    logic           pc_write;
    logic [1:0]     pc_src;
    logic           iord;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic [1:0]     alu_op;
    logic [1:0]     alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     wb_src;
    logic           mary_write;
    logic           shelley_write;
    logic           sp_write;
    logic           ra_write;
    logic           comp_write;
    logic [STW-1:0] state;
    logic           halted;

    modport master (
        input  opcode, comp, mem_wait, step,
        output pc_write, pc_src, iord, mem_read, mem_write, ir_write, alu_op,
               alu_src_a, alu_src_b, wb_src, mary_write, shelley_write, sp_write,
               ra_write, comp_write, state, halted
    );
    modport slave (
        output opcode, comp, mem_wait, step,
        input  pc_write, pc_src, iord, mem_read, mem_write, ir_write, alu_op,
               alu_src_a, alu_src_b, wb_src, mary_write, shelley_write, sp_write,
               ra_write, comp_write, state, halted
    );
endinterface

// File: rtl/frankie_control_outputs.sv
// frankie_control_outputs: combinational map from state and opcode to the
// datapath control word; quiet forces every strobe low.
module frankie_control_outputs
    import frankie_pkg::*;
(
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic           comp,
    input  logic           mem_wait,
    input  logic           quiet,
    output ctrl_t          ctrl
);
    ctrl_t c;

    always_comb begin
        c = '0;
        case (state)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_ONE;
                c.ir_write  = !mem_wait;
                c.pc_write  = !mem_wait;
            end
            DECODE, ADDR, SP_DEC, MEM_RD, MEM_WR: begin
                // address computation stays fixed so aluout holds across wait cycles
                c.alu_src_a = (opcode == OP_PUSH || opcode == OP_POP) ? SRCA_SP : SRCA_MARY;
                c.alu_src_b = (opcode == OP_PUSH) ? SRCB_NEG1 : SRCB_IMM;
                c.mem_read  = (state == MEM_RD);
                c.mem_write = (state == MEM_WR);
                c.iord      = (state == MEM_RD) || (state == MEM_WR);
                c.sp_write  = (state == SP_DEC);
            end
            EXEC, WB_ALU: begin
                c.alu_src_b  = (opcode == OP_ADDI) ? SRCB_IMM : SRCB_SHELLEY;
                c.alu_op     = (opcode == OP_SUB) ? ALU_SUB : (opcode == OP_SLT) ? ALU_SLT : ALU_ADD;
                c.comp_write = (state == WB_ALU) && (opcode == OP_SLT);
                c.mary_write = (state == WB_ALU) && (opcode != OP_SLT);
            end
            WB_IMM: begin
                c.wb_src        = WBS_IMM;
                c.mary_write    = (opcode == OP_LIM);
                c.shelley_write = (opcode == OP_LIS);
            end
            WB_MEM: begin
                c.wb_src     = WBS_MEM;
                c.mary_write = 1'b1;
            end
            WB_POP: begin
                c.alu_src_a  = SRCA_SP;
                c.alu_src_b  = SRCB_ONE;
                c.wb_src     = WBS_MEM;
                c.mary_write = 1'b1;
                c.sp_write   = 1'b1;
            end
            BR: begin
                c.pc_src   = PC_JUMP;
                c.pc_write = comp || (opcode == OP_J);
            end
            JMP: begin
                c.pc_src   = (opcode == OP_JR) ? PC_RA : PC_JUMP;
                c.pc_write = 1'b1;
                c.ra_write = (opcode == OP_JAL);
            end
            SWAP: begin
                c.wb_src        = WBS_SWAP;
                c.mary_write    = 1'b1;
                c.shelley_write = 1'b1;
            end
            HALT: c.halted = 1'b1;
            default: ;
        endcase
        ctrl = quiet ? '0 : c;
    end
endmodule

// File: rtl/frankie_control.sv
// frankie_control: multicycle fetch/decode/execute FSM for the Frankie datapath.
// FRANKIE_STEP_EN: FETCH idles with strobes low until a step pulse, then runs one instruction.
module frankie_control
    import frankie_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    frankie_control_if.master bus
);
    state_t state_q, state_d;
    logic   waiting;
    ctrl_t  ctrl;

`ifdef FRANKIE_STEP_EN
    logic go_q, go_d;
    // go captures a step seen while idle in FETCH and clears once that fetch completes
    always_comb go_d = (state_q == FETCH) ? (go_q ? bus.mem_wait : bus.step) : 1'b0;
    always_ff @(posedge clock) begin
        if (reset) go_q <= 1'b0;
        else       go_q <= go_d;
    end
    assign waiting = (state_q == FETCH) && !go_q;
`else
    logic unused_step;
    assign unused_step = bus.step;
    assign waiting     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = (waiting || bus.mem_wait) ? FETCH : DECODE;
            DECODE:  state_d = decode_next(bus.opcode);
            EXEC:    state_d = WB_ALU;
            ADDR:    state_d = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:  state_d = bus.mem_wait ? MEM_RD : (bus.opcode == OP_POP) ? WB_POP : WB_MEM;
            MEM_WR:  state_d = bus.mem_wait ? MEM_WR : FETCH;
            SP_DEC:  state_d = MEM_WR;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    frankie_control_outputs u_outputs (
        .state    (state_q),
        .opcode   (bus.opcode),
        .comp     (bus.comp),
        .mem_wait (bus.mem_wait),
        .quiet    (reset || waiting),
        .ctrl     (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.wb_src        = ctrl.wb_src;
    assign bus.mary_write    = ctrl.mary_write;
    assign bus.shelley_write = ctrl.shelley_write;
    assign bus.sp_write      = ctrl.sp_write;
    assign bus.ra_write      = ctrl.ra_write;
    assign bus.comp_write    = ctrl.comp_write;
    assign bus.halted        = ctrl.halted;
    assign bus.state         = state_q;
endmodule
